// File: rtl/ad9467fmc_pkg.sv
// ad9467fmc_pkg: shared capture state encoding and default widths
package ad9467fmc_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_NFRM_W = 16;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } capture_state_t;
endpackage

// File: rtl/ad9467_sync_edge.sv
// ad9467_sync_edge: 2-FF synchroniser with registered rising-edge pulse
module ad9467_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);
  logic r_meta, r_sync, r_prev;
  // two metastability stages, then one history stage for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end
  assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/ad9467_capture_ctrl.sv
// ad9467_capture_ctrl: arm/trigger capture sequencer from CDC FIFO to AXI-Stream master
module ad9467_capture_ctrl
  import ad9467fmc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int NFRM_W = DEF_NFRM_W
) (
  input  logic              m_aclk,
  input  logic              m_aresetn,
  input  logic              cfg_arm,
  input  logic              cfg_abort,
  input  logic              cfg_trig_ext,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic [NFRM_W-1:0] cfg_num_frames,
  input  logic              sts_clear,
  input  logic              trig_in,
  input  logic              fifo_overflow,
  input  logic              fifo_underflow,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_ovf,
  output logic              sts_unf,
  output logic [NFRM_W-1:0] sts_frames
);
  capture_state_t    r_state, w_next;
  logic [LEN_W-1:0]  r_beat, r_len;
  logic [NFRM_W-1:0] r_frames, r_nfrm, w_frames_inc;
  logic              r_ovf_prev, r_ovf, r_unf;
  logic              w_trig_rise, w_go, w_capture, w_flush, w_active;
  logic              w_beat, w_last, w_close, w_final, w_ovf_edge;

  ad9467_sync_edge u_trig_sync (
    .i_clk   (m_aclk),
    .i_rst_n (m_aresetn),
    .i_async (trig_in),
    .o_rise  (w_trig_rise)
  );

  assign w_go         = ~cfg_trig_ext | w_trig_rise;
  assign w_capture    = r_state == ST_CAPTURE;
  assign w_flush      = r_state == ST_FLUSH;
  assign w_active     = w_capture | w_flush;
  assign w_beat       = w_active & s_axis_tvalid & m_axis_tready;
  assign w_last       = w_capture & (r_beat == r_len - LEN_W'(1));
  assign w_close      = w_last | w_flush;
  assign w_frames_inc = r_frames + NFRM_W'(1);
  assign w_final      = (r_nfrm != '0) & (w_frames_inc == r_nfrm);
  assign w_ovf_edge   = fifo_overflow & ~r_ovf_prev;

  // state register
  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // next-state: a closing beat beats abort/overflow, and abort on it skips DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = cfg_arm ? ST_ARMED : ST_IDLE;
      ST_ARMED:   w_next = cfg_abort ? ST_IDLE : w_go ? ST_CAPTURE : ST_ARMED;
      ST_CAPTURE: begin
        if (w_beat && w_last)            w_next = cfg_abort ? ST_IDLE : w_final ? ST_DONE : ST_CAPTURE;
        else if (cfg_abort || w_ovf_edge) w_next = ST_FLUSH;
      end
      ST_FLUSH:   w_next = w_beat ? ST_IDLE : ST_FLUSH;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // beat/frame counters and capture configuration snapshot
  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_beat   <= '0;
      r_len    <= '0;
      r_nfrm   <= '0;
      r_frames <= '0;
    end else begin
      if (r_state == ST_IDLE && cfg_arm) begin
        r_frames <= '0;
        r_beat   <= '0;
      end
      if (r_state == ST_ARMED && !cfg_abort && w_go) begin
        r_len  <= (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
        r_nfrm <= cfg_num_frames;
        r_beat <= '0;
      end
      if (w_beat) begin
        r_beat   <= w_close ? '0 : r_beat + LEN_W'(1);
        r_frames <= (w_close && r_frames != '1) ? w_frames_inc : r_frames;
      end
    end
  end

  // sticky FIFO status; a set in the clearing cycle keeps the flag
  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_ovf_prev <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_ovf_prev <= fifo_overflow;
      r_ovf      <= fifo_overflow | (r_ovf & ~sts_clear);
      r_unf      <= fifo_underflow | (r_unf & ~sts_clear);
    end
  end

  assign m_axis_tvalid = w_active & s_axis_tvalid;
  assign s_axis_tready = w_active ? m_axis_tready : 1'b1;
  assign m_axis_tdata  = w_active ? s_axis_tdata : '0;
  assign m_axis_tlast  = w_close;
  assign sts_busy      = r_state != ST_IDLE;
  assign sts_done      = r_state == ST_DONE;
  assign sts_ovf       = r_ovf;
  assign sts_unf       = r_unf;
  assign sts_frames    = r_frames;
endmodule

// File: tb/tb_ad9467_capture_ctrl.sv
// tb_ad9467_capture_ctrl: scoreboard bench for the capture sequencer
module tb_ad9467_capture_ctrl;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 16;
  localparam int NFRM_W = 16;

  logic              m_aclk = 1'b0;
  logic              m_aresetn = 1'b0;
  logic              cfg_arm = 1'b0, cfg_abort = 1'b0, cfg_trig_ext = 1'b0;
  logic [LEN_W-1:0]  cfg_frame_len = '0;
  logic [NFRM_W-1:0] cfg_num_frames = '0;
  logic              sts_clear = 1'b0, trig_in = 1'b0;
  logic              fifo_overflow = 1'b0, fifo_underflow = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              sts_busy, sts_done, sts_ovf, sts_unf;
  logic [NFRM_W-1:0] sts_frames;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [DATA_W-1:0] seq = 16'h0100;
  logic [DATA_W:0]   sb[$];

  ad9467_capture_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .NFRM_W(NFRM_W)) dut (
    .m_aclk(m_aclk), .m_aresetn(m_aresetn),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_trig_ext(cfg_trig_ext),
    .cfg_frame_len(cfg_frame_len), .cfg_num_frames(cfg_num_frames),
    .sts_clear(sts_clear), .trig_in(trig_in),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_ovf(sts_ovf), .sts_unf(sts_unf),
    .sts_frames(sts_frames)
  );

  always #5 m_aclk = ~m_aclk;

  always @(negedge m_aclk) if (sts_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_aclk);
    #1;
  endtask

  task automatic arm(input int len, input int nfrm, input bit ext);
    cfg_frame_len  = LEN_W'(len);
    cfg_num_frames = NFRM_W'(nfrm);
    cfg_trig_ext   = ext;
    cfg_arm        = 1'b1;
    tick();
    cfg_arm = 1'b0;
    if (!ext) tick();
  endtask

  task automatic stream(input int n, input int len, input bit bp, input int idx0, input bit flush_last);
    int acc = 0;
    int guard = 0;
    logic lst;
    logic [DATA_W:0] e;
    while (acc < n && guard < 4 * n + 100) begin
      s_axis_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata  = seq;
      @(negedge m_aclk);
      if (s_axis_tvalid && s_axis_tready) begin
        lst = (flush_last && acc == n - 1) || ((idx0 + acc) % len == len - 1);
        sb.push_back({lst, seq});
        seq++;
        acc++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) check("spurious_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("tdata", 32'(m_axis_tdata), 32'(e[DATA_W-1:0]));
          check("tlast", 32'(m_axis_tlast), 32'(e[DATA_W]));
        end
      end
      tick();
      guard++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    if (acc < n) check("stream_timeout", 32'(acc), 32'(n));
    check("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge m_aclk);
    @(negedge m_aclk) m_aresetn = 1'b1;
    tick();
    check("rst_busy", 32'(sts_busy), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_frames", 32'(sts_frames), 32'd0);
    check("rst_flags", 32'({sts_done, sts_ovf, sts_unf}), 32'd0);
    check("rst_sready", 32'(s_axis_tready), 32'd1);

    // T1: two frames of four beats, immediate start
    arm(4, 2, 1'b0);
    check("t1_busy", 32'(sts_busy), 32'd1);
    stream(8, 4, 1'b0, 0, 1'b0);
    s_axis_tvalid = 1'b1;
    check("t1_done", 32'(sts_done), 32'd1);
    check("t1_frames", 32'(sts_frames), 32'd2);
    check("t1_drop_done", 32'(m_axis_tvalid), 32'd0);
    tick();
    s_axis_tvalid = 1'b0;
    check("t1_done_pulse", 32'(sts_done), 32'd0);
    check("t1_idle", 32'(sts_busy), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // T2: external trigger; pre-trigger samples dropped
    arm(4, 1, 1'b1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'hDEAD;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("t2_pre_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("t2_pre_tready", 32'(s_axis_tready), 32'd1);
    end
    trig_in = 1'b1;
    lat = 0;
    while (lat < 8 && !m_axis_tvalid) begin
      tick();
      lat++;
    end
    check("t2_latency_ok", 32'(lat >= 2 && lat <= 3), 32'd1);
    stream(4, 4, 1'b0, 0, 1'b0);
    trig_in = 1'b0;
    check("t2_done", 32'(sts_done), 32'd1);
    check("t2_frames", 32'(sts_frames), 32'd1);
    tick();

    // T3: back-pressure, config changed after capture start must be ignored
    arm(8, 3, 1'b0);
    cfg_frame_len  = 16'd3;
    cfg_num_frames = 16'd1;
    stream(24, 8, 1'b1, 0, 1'b0);
    check("t3_done", 32'(sts_done), 32'd1);
    check("t3_frames", 32'(sts_frames), 32'd3);
    tick();
    check("t3_done_cnt", 32'(done_cnt), 32'd3);

    // T4: abort after three beats, flush beat closes the frame
    arm(8, 0, 1'b0);
    stream(3, 8, 1'b0, 0, 1'b0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("t4_flush_busy", 32'(sts_busy), 32'd1);
    stream(1, 8, 1'b0, 3, 1'b1);
    check("t4_idle", 32'(sts_busy), 32'd0);
    check("t4_frames", 32'(sts_frames), 32'd1);
    tick();
    check("t4_no_done", 32'(done_cnt), 32'd3);

    // T5: overflow edge mid-frame, sticky flag priority, underflow
    arm(8, 0, 1'b0);
    stream(3, 8, 1'b0, 0, 1'b0);
    fifo_overflow = 1'b1;
    tick();
    fifo_overflow = 1'b0;
    check("t5_ovf", 32'(sts_ovf), 32'd1);
    check("t5_flush_busy", 32'(sts_busy), 32'd1);
    stream(1, 8, 1'b0, 3, 1'b1);
    check("t5_idle", 32'(sts_busy), 32'd0);
    check("t5_frames", 32'(sts_frames), 32'd1);
    check("t5_ovf_held", 32'(sts_ovf), 32'd1);
    fifo_overflow = 1'b1;
    sts_clear = 1'b1;
    tick();
    fifo_overflow = 1'b0;
    check("t5_set_wins", 32'(sts_ovf), 32'd1);
    tick();
    sts_clear = 1'b0;
    check("t5_ovf_clr", 32'(sts_ovf), 32'd0);
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    repeat (3) tick();
    check("t5_unf", 32'(sts_unf), 32'd1);
    sts_clear = 1'b1;
    tick();
    sts_clear = 1'b0;
    check("t5_unf_clr", 32'(sts_unf), 32'd0);
    check("t5_no_done", 32'(done_cnt), 32'd3);

    // T6: continuous single-beat frames saturate the frame counter, then async reset
    arm(1, 0, 1'b0);
    stream(70000, 1, 1'b0, 0, 1'b0);
    check("t6_sat", 32'(sts_frames), 32'h0000_FFFF);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'h5A5A;
    check("t6_live", 32'(m_axis_tvalid), 32'd1);
    #2 m_aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("t6_rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("t6_rst_busy", 32'(sts_busy), 32'd0);
    check("t6_rst_frames", 32'(sts_frames), 32'd0);
    s_axis_tvalid = 1'b0;
    @(negedge m_aclk) m_aresetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
